// File: rtl/mac_mesh_acc_pkg.sv
// Shared types and saturating-add helper for the MAC mesh accumulator.
package mac_mesh_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Working width for the saturating add; wide enough for any sane OUT_BIT.
    localparam int unsigned CALC_W = 64;

    typedef struct packed {
        logic              sat;
        logic [CALC_W-1:0] sum;
    } sat_res_t;

    // Adds two extended operands one bit wider than they are and clamps the
    // result to the range of a 'width'-bit signed or unsigned number.
    function automatic sat_res_t sat_add(input logic [CALC_W-1:0] a,
                                         input logic [CALC_W-1:0] b,
                                         input int unsigned       width,
                                         input logic              signed_mode);
        logic signed [CALC_W:0] one;
        logic signed [CALC_W:0] sum;
        logic signed [CALC_W:0] maxv;
        logic signed [CALC_W:0] minv;
        sat_res_t               r;
        one = 1;
        sum = $signed({a[CALC_W-1], a}) + $signed({b[CALC_W-1], b});
        if (signed_mode) begin
            maxv = (one <<< (width - 1)) - one;
            minv = -(one <<< (width - 1));
        end else begin
            maxv = (one <<< width) - one;
            minv = '0;
        end
        if (sum > maxv) begin
            r.sat = 1'b1;
            r.sum = maxv[CALC_W-1:0];
        end else if (sum < minv) begin
            r.sat = 1'b1;
            r.sum = minv[CALC_W-1:0];
        end else begin
            r.sat = 1'b0;
            r.sum = sum[CALC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_mesh_acc_lane.sv
// One mesh lane: multiply pixel by row weight and saturate-accumulate into a
// private accumulator, with a sticky per-lane saturation bit.
module mesh_acc_lane
    import mac_mesh_acc_pkg::*;
#(
    parameter int IN_BIT     = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int OUT_BIT    = 20,
    parameter int SIGNED     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IN_BIT-1:0]     data_i,
    input  logic [WEIGHT_BIT-1:0] weight_i,
    input  logic                  acc_en_i,
    input  logic                  acc_load_i,
    input  logic                  acc_zero_i,
    output logic [OUT_BIT-1:0]    acc_o,
    output logic                  sat_o
);

    localparam int PROD_W = IN_BIT + WEIGHT_BIT;

    logic [CALC_W-1:0]  prodExt;
    logic [CALC_W-1:0]  baseExt;
    logic [OUT_BIT-1:0] acc_q;
    logic               sat_q;
    sat_res_t           res;

    // Product and accumulator extension follow the data format; the first
    // beat of a tile starts from zero instead of the old accumulator.
    if (SIGNED != 0) begin : g_signed
        logic signed [PROD_W-1:0] dataS;
        logic signed [PROD_W-1:0] weightS;
        logic signed [PROD_W-1:0] prodS;
        assign dataS   = PROD_W'($signed(data_i));
        assign weightS = PROD_W'($signed(weight_i));
        assign prodS   = dataS * weightS;
        assign prodExt = {{(CALC_W-PROD_W){prodS[PROD_W-1]}}, prodS};
        assign baseExt = acc_load_i ? '0 : {{(CALC_W-OUT_BIT){acc_q[OUT_BIT-1]}}, acc_q};
    end else begin : g_unsigned
        logic [PROD_W-1:0] prodU;
        assign prodU   = PROD_W'(data_i) * PROD_W'(weight_i);
        assign prodExt = {{(CALC_W-PROD_W){1'b0}}, prodU};
        assign baseExt = acc_load_i ? '0 : {{(CALC_W-OUT_BIT){1'b0}}, acc_q};
    end

    assign res = sat_add(baseExt, prodExt, OUT_BIT, SIGNED != 0);

    // Accumulator register: zero wins, load opens a fresh tile, enable adds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (acc_zero_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (acc_load_i) begin
            acc_q <= res.sum[OUT_BIT-1:0];
            sat_q <= res.sat;
        end else if (acc_en_i) begin
            acc_q <= res.sum[OUT_BIT-1:0];
            sat_q <= sat_q | res.sat;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/mac_mesh_acc.sv
// MAC mesh top: tile FSM, beat counter and an array of accumulating lanes
// whose results are held behind a valid/ready output handshake.
module mac_mesh_acc
    import mac_mesh_acc_pkg::*;
#(
    parameter int IN_BIT     = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int OUT_BIT    = 20,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4,
    parameter int LEN_BIT    = 8,
    parameter int SIGNED     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clr_i,
    input  logic [LEN_BIT-1:0]                acc_len_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [MESH_X*MESH_Y*IN_BIT-1:0]   data_in_i,
    input  logic [MESH_Y*WEIGHT_BIT-1:0]      weight_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [MESH_X*MESH_Y*OUT_BIT-1:0]  data_out_o,
    output logic                              sat_flag_o
);

    localparam int LANES = MESH_X * MESH_Y;

    state_e             state_q;
    logic [LEN_BIT-1:0] count_q;
    logic [LEN_BIT-1:0] len_q;
    logic [LEN_BIT-1:0] len_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               beat;
    logic               accLoad;
    logic               accEn;
    logic               accZero;
    logic [LANES-1:0]   laneSat;

    assign beat    = in_valid_i & in_ready_q & ~clr_i;
    assign len_d   = (acc_len_i == '0) ? LEN_BIT'(1) : acc_len_i;
    assign accLoad = beat & (state_q == IDLE);
    assign accEn   = beat & (state_q == ACCUM);
    assign accZero = clr_i | ((state_q == DONE) & out_ready_i);

    // Tile sequencing with registered handshake outputs; clr overrides all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (clr_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        len_q <= len_d;
                        if (len_d == LEN_BIT'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                            count_q <= LEN_BIT'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        count_q <= count_q + LEN_BIT'(1);
                        if (count_q == len_q - LEN_BIT'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    count_q     <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar idx = 0; idx < LANES; idx++) begin : g_lane
        mesh_acc_lane #(
            .IN_BIT    (IN_BIT),
            .WEIGHT_BIT(WEIGHT_BIT),
            .OUT_BIT   (OUT_BIT),
            .SIGNED    (SIGNED)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .data_i    (data_in_i[(idx+1)*IN_BIT-1 -: IN_BIT]),
            .weight_i  (weight_i[(idx/MESH_X+1)*WEIGHT_BIT-1 -: WEIGHT_BIT]),
            .acc_en_i  (accEn),
            .acc_load_i(accLoad),
            .acc_zero_i(accZero),
            .acc_o     (data_out_o[(idx+1)*OUT_BIT-1 -: OUT_BIT]),
            .sat_o     (laneSat[idx])
        );
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sat_flag_o  = |laneSat;

endmodule

// File: tb/tb_mac_mesh_acc.sv
// Directed bench for the MAC mesh: a 2x2 signed 20-bit mesh, a 16-bit copy
// for clamping, and an unsigned copy, all driven by the same stimulus.
module tb_mac_mesh_acc;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clr;
    logic [7:0]  accLen;
    logic        inValid;
    logic [31:0] dataIn;
    logic [15:0] weight;
    logic        outReady;

    logic        inReady,  inReady16,  inReadyU;
    logic        outValid, outValid16, outValidU;
    logic [79:0] dataOut,  dataOutU;
    logic [63:0] dataOut16;
    logic        satFlag,  satFlag16,  satFlagU;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_mesh_acc #(.IN_BIT(8), .WEIGHT_BIT(8), .OUT_BIT(20), .MESH_X(2), .MESH_Y(2),
                   .LEN_BIT(8), .SIGNED(1)) dut (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .acc_len_i(accLen),
        .in_valid_i(inValid), .in_ready_o(inReady), .data_in_i(dataIn),
        .weight_i(weight), .out_valid_o(outValid), .out_ready_i(outReady),
        .data_out_o(dataOut), .sat_flag_o(satFlag));

    mac_mesh_acc #(.IN_BIT(8), .WEIGHT_BIT(8), .OUT_BIT(16), .MESH_X(2), .MESH_Y(2),
                   .LEN_BIT(8), .SIGNED(1)) dut16 (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .acc_len_i(accLen),
        .in_valid_i(inValid), .in_ready_o(inReady16), .data_in_i(dataIn),
        .weight_i(weight), .out_valid_o(outValid16), .out_ready_i(outReady),
        .data_out_o(dataOut16), .sat_flag_o(satFlag16));

    mac_mesh_acc #(.IN_BIT(8), .WEIGHT_BIT(8), .OUT_BIT(20), .MESH_X(2), .MESH_Y(2),
                   .LEN_BIT(8), .SIGNED(0)) dutU (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .acc_len_i(accLen),
        .in_valid_i(inValid), .in_ready_o(inReadyU), .data_in_i(dataIn),
        .weight_i(weight), .out_valid_o(outValidU), .out_ready_i(outReady),
        .data_out_o(dataOutU), .sat_flag_o(satFlagU));

    // Advance one clock; everything is driven and sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat: same pixel on every lane, per-row weights.
    task automatic applyStimulus(input logic valid, input logic [7:0] len,
                                 input logic [7:0] d, input logic [7:0] w0,
                                 input logic [7:0] w1);
        inValid = valid;
        accLen  = len;
        dataIn  = {4{d}};
        weight  = {w1, w0};
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] obs,
                               input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Lanes 0,1 sit in row 0 and lanes 2,3 in row 1.
    function automatic logic [79:0] rows20(input logic [19:0] r0, input logic [19:0] r1);
        return {r1, r1, r0, r0};
    endfunction

    function automatic logic [79:0] rows16(input logic [15:0] r0, input logic [15:0] r1);
        return {16'h0, r1, r1, r0, r0};
    endfunction

    initial begin
        rstN     = 1'b0;
        clr      = 1'b0;
        outReady = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        checkOutput("reset_in_ready",  80'(inReady),  80'd1);
        checkOutput("reset_out_valid", 80'(outValid), 80'd0);
        checkOutput("reset_data_out",  dataOut,       80'd0);
        checkOutput("reset_sat_flag",  80'(satFlag),  80'd0);
        rstN = 1'b1;
        tick();

        // Tile of 3 with a gap and a mid-tile acc_len change that must be ignored.
        applyStimulus(1'b1, 8'd3, 8'd1, 8'd2, 8'hFF);
        tick();
        applyStimulus(1'b1, 8'd7, 8'd2, 8'd2, 8'hFF);
        tick();
        applyStimulus(1'b0, 8'd7, 8'd0, 8'd2, 8'hFF);
        tick();
        checkOutput("t1_gap_in_ready", 80'(inReady), 80'd1);
        applyStimulus(1'b1, 8'd7, 8'd3, 8'd2, 8'hFF);
        checkOutput("t1_pre_out_valid", 80'(outValid), 80'd0);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t1_out_valid", 80'(outValid), 80'd1);
        checkOutput("t1_in_ready",  80'(inReady),  80'd0);
        checkOutput("t1_data_out",  dataOut,  rows20(20'd12, 20'hFFFFA));
        checkOutput("t1_data16",    80'(dataOut16), rows16(16'd12, 16'hFFFA));
        checkOutput("t1_data_uns",  dataOutU, rows20(20'd12, 20'd1530));
        checkOutput("t1_sat_flag",  80'(satFlag), 80'd0);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("t1_retired_valid", 80'(outValid), 80'd0);
        checkOutput("t1_retired_data",  dataOut,       80'd0);

        // acc_len of 0 behaves as a single-beat tile.
        applyStimulus(1'b1, 8'd0, 8'd5, 8'd3, 8'd3);
        tick();
        checkOutput("t2_out_valid", 80'(outValid), 80'd1);
        checkOutput("t2_data_out",  dataOut, rows20(20'd15, 20'd15));

        // Backpressure: five stalled cycles with a beat waiting at the input.
        applyStimulus(1'b1, 8'd1, 8'd9, 8'd9, 8'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t3_in_ready",  80'(inReady),  80'd0);
            checkOutput("t3_out_valid", 80'(outValid), 80'd1);
            checkOutput("t3_data_hold", dataOut, rows20(20'd15, 20'd15));
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t3_retired_valid", 80'(outValid), 80'd0);
        checkOutput("t3_retired_ready", 80'(inReady),  80'd1);
        checkOutput("t3_retired_data",  dataOut,       80'd0);

        // Clamp on the 16-bit mesh; the 20-bit mesh holds 4*16129 exactly.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'd4, 8'd127, 8'd127, 8'd127);
            tick();
        end
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t4_valid16", 80'(outValid16), 80'd1);
        checkOutput("t4_data16",  80'(dataOut16), rows16(16'h7FFF, 16'h7FFF));
        checkOutput("t4_sat16",   80'(satFlag16), 80'd1);
        checkOutput("t4_data20",  dataOut, rows20(20'd64516, 20'd64516));
        checkOutput("t4_sat20",   80'(satFlag), 80'd0);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("t4_sat16_cleared", 80'(satFlag16), 80'd0);
        applyStimulus(1'b1, 8'd1, 8'd2, 8'd3, 8'hFD);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t4_next_data16", 80'(dataOut16), rows16(16'd6, 16'hFFFA));
        checkOutput("t4_next_sat16",  80'(satFlag16), 80'd0);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;

        // clr on the second beat of a 4-beat tile drops it entirely.
        applyStimulus(1'b1, 8'd4, 8'd7, 8'd7, 8'd7);
        tick();
        clr = 1'b1;
        checkOutput("t5_clr_ready_reads_state", 80'(inReady), 80'd1);
        tick();
        clr = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t5_clr_data", dataOut, 80'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5_no_valid", 80'(outValid), 80'd0);
        end
        applyStimulus(1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t5_after_valid", 80'(outValid), 80'd1);
        checkOutput("t5_after_data",  dataOut, rows20(20'd1, 20'd1));
        outReady = 1'b1;
        tick();
        outReady = 1'b0;

        // Asynchronous reset mid-ACCUM.
        applyStimulus(1'b1, 8'd4, 8'd3, 8'd3, 8'd3);
        tick();
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("t6_accum_rst_data",  dataOut,       80'd0);
        checkOutput("t6_accum_rst_valid", 80'(outValid), 80'd0);
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("t6_accum_rel_ready", 80'(inReady), 80'd1);

        // Asynchronous reset while holding a result, then the unsigned check.
        applyStimulus(1'b1, 8'd1, 8'd255, 8'd255, 8'd255);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("t6_uns_valid", 80'(outValidU), 80'd1);
        checkOutput("t6_uns_data",  dataOutU, rows20(20'd65025, 20'd65025));
        checkOutput("t6_sgn_data",  dataOut,  rows20(20'd1, 20'd1));
        #1 rstN = 1'b0;
        #1;
        checkOutput("t6_done_rst_valid", 80'(outValid), 80'd0);
        checkOutput("t6_done_rst_data",  dataOutU,      80'd0);
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("t6_done_rel_ready", 80'(inReady), 80'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
